// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
//
// Run controller for a small binary counter datapath. A host issues a start
// together with a terminal count (limit) and a repeat count (reps). The block
// then clears the external counter and enables it for (limit+1)*(reps+1)
// counting cycles. It keeps a registered shadow copy of the count so the host
// can observe progress without reading the datapath. Pause freezes the run and
// abort cancels it.
//
// Ports
//   clock      in   1       system clock, rising edge
//   clear_n    in   1       asynchronous active-low reset
//   start      in   1       begin a run (sampled only in IDLE, level-sensitive)
//   limit      in   WIDTH   terminal count, latched at start
//   reps       in   RWIDTH  number of rounds minus one, latched at start
//   pause      in   1       level, freezes counting while high
//   abort      in   1       level, cancels the run in progress
//   cnt_clear  out  1       synchronous clear to the counter datapath
//   cnt_en     out  1       count enable to the counter datapath
//   count      out  WIDTH   shadow count (registered)
//   rep_count  out  RWIDTH  completed rounds (registered)
//   busy       out  1       high in LOAD, RUN and HOLD
//   done       out  1       one-cycle pulse when a run completes normally
//   wrap       out  1       registered pulse the cycle after count wraps to 0
// -----------------------------------------------------------------------------
module counter_sequencer #(
   parameter int WIDTH  = 2,
   parameter int RWIDTH = 2
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic              start,
   input  logic [WIDTH-1:0]  limit,
   input  logic [RWIDTH-1:0] reps,
   input  logic              pause,
   input  logic              abort,
   output logic              cnt_clear,
   output logic              cnt_en,
   output logic [WIDTH-1:0]  count,
   output logic [RWIDTH-1:0] rep_count,
   output logic              busy,
   output logic              done,
   output logic              wrap
);

   localparam logic [WIDTH-1:0]  CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1'b1);
   localparam logic [RWIDTH-1:0] REP_ZERO = {RWIDTH{1'b0}};
   localparam logic [RWIDTH-1:0] REP_ONE  = RWIDTH'(1'b1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_HOLD = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  limit_q, limit_d;
   logic [RWIDTH-1:0] reps_q, reps_d;
   logic [WIDTH-1:0]  count_q, count_d;
   logic [RWIDTH-1:0] rep_count_q, rep_count_d;
   logic              wrap_q, wrap_d;
   logic              cnt_clear_s;
   logic              cnt_en_s;

   // Round and run completion are judged against the latched copies only, so
   // host changes to limit/reps mid-run cannot disturb the sequence.
   logic round_end_s;
   logic last_round_s;
   assign round_end_s  = (count_q == limit_q);
   assign last_round_s = (rep_count_q == reps_q);

   // Next-state, next-datapath and counter-control decode
   always_comb begin
      state_d     = state_q;
      limit_d     = limit_q;
      reps_d      = reps_q;
      count_d     = count_q;
      rep_count_d = rep_count_q;
      wrap_d      = 1'b0;
      cnt_clear_s = 1'b0;
      cnt_en_s    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               limit_d = limit;
               reps_d  = reps;
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_LOAD: begin
            // The external counter is cleared here regardless of abort; the
            // shadow count is zeroed on both paths so the two stay aligned.
            cnt_clear_s = 1'b1;
            count_d     = CNT_ZERO;
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               rep_count_d = REP_ZERO;
               state_d     = ST_RUN;
            end
         end

         ST_RUN: begin
            // abort beats pause, and pause beats counting/completion.
            if (abort) begin
               count_d = CNT_ZERO;
               state_d = ST_IDLE;
            end else if (pause) begin
               state_d = ST_HOLD;
            end else begin
               cnt_en_s = 1'b1;
               if (!round_end_s) begin
                  count_d = count_q + CNT_ONE;
                  state_d = ST_RUN;
               end else begin
                  count_d = CNT_ZERO;
                  wrap_d  = 1'b1;
                  if (last_round_s) begin
                     state_d = ST_DONE;
                  end else begin
                     rep_count_d = rep_count_q + REP_ONE;
                     state_d     = ST_RUN;
                  end
               end
            end
         end

         ST_HOLD: begin
            if (abort) begin
               count_d = CNT_ZERO;
               state_d = ST_IDLE;
            end else if (pause) begin
               state_d = ST_HOLD;
            end else begin
               // Enable stays low this cycle; counting resumes in RUN.
               state_d = ST_RUN;
            end
         end

         ST_DONE: begin
            // start is deliberately not looked at here, so a held start
            // always passes through one IDLE cycle between runs.
            state_d = ST_IDLE;
         end

         default: begin
            // Unreachable encodings recover to a clean idle state.
            count_d     = CNT_ZERO;
            rep_count_d = REP_ZERO;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State, latched run parameters and registered status
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q     <= ST_IDLE;
         limit_q     <= CNT_ZERO;
         reps_q      <= REP_ZERO;
         count_q     <= CNT_ZERO;
         rep_count_q <= REP_ZERO;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         limit_q     <= limit_d;
         reps_q      <= reps_d;
         count_q     <= count_d;
         rep_count_q <= rep_count_d;
         wrap_q      <= wrap_d;
      end
   end

   // cnt_clear/cnt_en react to pause/abort in the same cycle so the external
   // counter never advances on a cycle where the shadow count does not.
   assign cnt_clear = cnt_clear_s;
   assign cnt_en    = cnt_en_s;

   // busy/done come only from the state register, so they never glitch on
   // input changes.
   assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_HOLD);
   assign done      = (state_q == ST_DONE);

   assign count     = count_q;
   assign rep_count = rep_count_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_sequencer
//
// Directed self-checking bench for counter_sequencer. Inputs are changed
// shortly after a rising edge, and outputs are sampled 2 time units after the
// edge. Expected values are written out by hand for each step.
// -----------------------------------------------------------------------------
module tb_counter_sequencer;

   localparam int WIDTH  = 2;
   localparam int RWIDTH = 2;

   logic              clock = 1'b0;
   logic              clear_n;
   logic              start;
   logic [WIDTH-1:0]  limit;
   logic [RWIDTH-1:0] reps;
   logic              pause;
   logic              abort;
   logic              cnt_clear;
   logic              cnt_en;
   logic [WIDTH-1:0]  count;
   logic [RWIDTH-1:0] rep_count;
   logic              busy;
   logic              done;
   logic              wrap;

   int checks   = 0;
   int failures = 0;
   int en_cnt;
   int wrap_cnt;
   int done_cnt;
   logic [7:0] exp_busy;
   logic [7:0] exp_done;
   logic [7:0] exp_clr;
   logic [7:0] exp_en;

   counter_sequencer #(.WIDTH(WIDTH), .RWIDTH(RWIDTH)) dut (
      .clock     (clock),
      .clear_n   (clear_n),
      .start     (start),
      .limit     (limit),
      .reps      (reps),
      .pause     (pause),
      .abort     (abort),
      .cnt_clear (cnt_clear),
      .cnt_en    (cnt_en),
      .count     (count),
      .rep_count (rep_count),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   initial begin
      clear_n = 1'b0;
      start   = 1'b0;
      pause   = 1'b0;
      abort   = 1'b0;
      limit   = 2'd0;
      reps    = 2'd0;
      #2;

      // ---- reset state ----
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count, 0);
      chk("rst_rep", rep_count, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_en", cnt_en, 0);
      chk("rst_clr", cnt_clear, 0);
      cyc();
      clear_n = 1'b1;
      cyc();
      chk("idle_busy", busy, 0);

      // ---- limit=3, reps=0: basic run and latency ----
      limit = 2'd3; reps = 2'd0; start = 1'b1;
      cyc();                                   // LOAD
      chk("t2_clr", cnt_clear, 1);
      chk("t2_busy_load", busy, 1);
      chk("t2_en_load", cnt_en, 0);
      start = 1'b0; limit = 2'd0; reps = 2'd3; // must be ignored mid-run
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t2_en", cnt_en, 1);
         chk("t2_count", count, i);
         chk("t2_clr_run", cnt_clear, 0);
      end
      cyc();                                   // DONE
      chk("t2_done", done, 1);
      chk("t2_wrap", wrap, 1);
      chk("t2_count_end", count, 0);
      chk("t2_busy_done", busy, 0);
      chk("t2_en_done", cnt_en, 0);
      cyc();                                   // IDLE
      chk("t2_done_off", done, 0);
      chk("t2_wrap_off", wrap, 0);

      // ---- async reset mid-run at count=2 ----
      limit = 2'd3; reps = 2'd0; start = 1'b1;
      cyc();                                   // LOAD
      start = 1'b0;
      cyc(); cyc(); cyc();                     // count 0,1,2
      chk("t1_pre_count", count, 2);
      clear_n = 1'b0;
      #1;
      chk("t1_busy", busy, 0);
      chk("t1_count", count, 0);
      chk("t1_en", cnt_en, 0);
      chk("t1_done", done, 0);
      cyc();
      clear_n = 1'b1;
      cyc();
      chk("t1_idle_busy", busy, 0);
      chk("t1_idle_count", count, 0);

      // ---- limit=1, reps=2: three rounds ----
      limit = 2'd1; reps = 2'd2; start = 1'b1;
      cyc();                                   // LOAD
      start = 1'b0;
      en_cnt = 0; wrap_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         cyc();
         if (cnt_en) en_cnt++;
         if (wrap) wrap_cnt++;
         chk("t3_count", count, k % 2);
         chk("t3_rep", rep_count, k / 2);
         chk("t3_busy", busy, 1);
      end
      cyc();                                   // DONE
      if (wrap) wrap_cnt++;
      chk("t3_done", done, 1);
      chk("t3_rep_end", rep_count, 2);
      chk("t3_en_cycles", en_cnt, 6);
      chk("t3_wraps", wrap_cnt, 3);
      cyc();
      chk("t3_done_off", done, 0);

      // ---- limit=3, pause for 3 cycles at count=2 ----
      limit = 2'd3; reps = 2'd0; start = 1'b1;
      cyc();                                   // LOAD
      start = 1'b0; en_cnt = 0;
      cyc(); if (cnt_en) en_cnt++;
      chk("t4_c0", count, 0);
      cyc(); if (cnt_en) en_cnt++;
      chk("t4_c1", count, 1);
      cyc();                                   // RUN count=2
      pause = 1'b1;
      #1;
      for (int p = 0; p < 3; p++) begin
         chk("t4_hold_count", count, 2);
         chk("t4_hold_en", cnt_en, 0);
         chk("t4_hold_busy", busy, 1);
         if (cnt_en) en_cnt++;
         cyc();
      end
      pause = 1'b0;
      #1;
      chk("t4_release_en", cnt_en, 0);
      chk("t4_release_count", count, 2);
      cyc(); if (cnt_en) en_cnt++;
      chk("t4_resume_count", count, 2);
      cyc(); if (cnt_en) en_cnt++;
      chk("t4_c3", count, 3);
      cyc();
      chk("t4_done", done, 1);
      chk("t4_count_end", count, 0);
      chk("t4_en_cycles", en_cnt, 4);
      cyc();

      // ---- abort in HOLD at count=1 (second round) ----
      limit = 2'd1; reps = 2'd1; start = 1'b1;
      cyc();                                   // LOAD
      start = 1'b0;
      cyc(); cyc(); cyc();                     // c0r0, c1r0, c0r1
      chk("t5_r1_count", count, 0);
      chk("t5_r1_rep", rep_count, 1);
      chk("t5_r1_wrap", wrap, 1);
      cyc();                                   // c1r1
      pause = 1'b1;
      cyc();                                   // HOLD
      chk("t5_hold_count", count, 1);
      abort = 1'b1;
      #1;
      chk("t5_abort_en", cnt_en, 0);
      chk("t5_abort_busy", busy, 1);
      cyc();                                   // IDLE
      abort = 1'b0; pause = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_count", count, 0);
      chk("t5_rep_hold", rep_count, 1);
      chk("t5_no_done", done, 0);
      cyc();
      chk("t5_no_done2", done, 0);
      limit = 2'd0; reps = 2'd1; start = 1'b1;
      cyc();                                   // LOAD
      start = 1'b0;
      chk("t5_load_clr", cnt_clear, 1);
      cyc();
      chk("t5_new_rep0", rep_count, 0);
      chk("t5_new_en", cnt_en, 1);
      cyc();
      chk("t5_new_rep1", rep_count, 1);
      chk("t5_new_wrap", wrap, 1);
      cyc();
      chk("t5_new_done", done, 1);
      cyc();

      // ---- abort beats completion ----
      limit = 2'd0; reps = 2'd0; start = 1'b1;
      cyc();                                   // LOAD
      start = 1'b0;
      cyc();                                   // RUN, would complete
      abort = 1'b1;
      #1;
      chk("t5b_en", cnt_en, 0);
      cyc();
      abort = 1'b0;
      chk("t5b_done", done, 0);
      chk("t5b_wrap", wrap, 0);
      chk("t5b_busy", busy, 0);

      // ---- start held, limit=0, reps=0: back-to-back runs ----
      exp_busy = 8'b0011_0011;
      exp_done = 8'b0100_0100;
      exp_clr  = 8'b0001_0001;
      exp_en   = 8'b0010_0010;
      limit = 2'd0; reps = 2'd0; start = 1'b1;
      cyc();                                   // LOAD
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         chk("t6_busy", busy, exp_busy[i]);
         chk("t6_done", done, exp_done[i]);
         chk("t6_clr", cnt_clear, exp_clr[i]);
         chk("t6_en", cnt_en, exp_en[i]);
         if (done) done_cnt++;
         cyc();
      end
      chk("t6_done_count", done_cnt, 2);
      start = 1'b0;
      cyc(); cyc(); cyc();
      chk("t6_final_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
